// File: rtl/win_pkg.sv
// Shared constants and state encoding for the Winograd F(6,4) input path.
// Used by win_tile_builder, the wc core and the downstream stage.
//   DW     : sample width (two's complement)
//   M      : outputs per tile, i.e. tile stride
//   R      : filter taps; consecutive tiles overlap by R-1 samples
//   T      : samples per tile (M+R-1)
//   TILE_W : width of one packed tile word
package win_pkg;

  localparam int unsigned DW     = 10;
  localparam int unsigned M      = 6;
  localparam int unsigned R      = 4;
  localparam int unsigned T      = M + R - 1;
  localparam int unsigned TILE_W = T * DW;

  // Fill counter spans 0..T inclusive.
  localparam int unsigned CW = $clog2(T + 1);

  localparam logic [CW-1:0] CNT_FULL    = CW'(T);
  localparam logic [CW-1:0] CNT_OVERLAP = CW'(R - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    PAD  = 2'd2
  } state_t;

endpackage

// File: rtl/win_tile_builder_if.sv
// Handshake bundle around win_tile_builder.
//   in_valid/in_ready/in_data/in_last     : serial sample stream
//   tile_valid/tile_ready/tile_data/tile_last : packed tile stream to wc
// slave  : view of the tile builder itself
// master : view of the environment (sample producer + tile consumer)
interface win_tile_builder_if;
  import win_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_last;

  logic              tile_valid;
  logic              tile_ready;
  logic [TILE_W-1:0] tile_data;
  logic              tile_last;

  modport slave (
    input  in_valid, in_data, in_last, tile_ready,
    output in_ready, tile_valid, tile_data, tile_last
  );

  modport master (
    output in_valid, in_data, in_last, tile_ready,
    input  in_ready, tile_valid, tile_data, tile_last
  );

endinterface

// File: rtl/win_tile_builder.sv
// Assembles overlapping T-sample tiles (stride M, overlap R-1) from a serial
// sample stream and presents each as one TILE_W-bit word. The final partial
// tile of a stream is zero-padded and flagged with tile_last.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : win_tile_builder_if.slave (sample input + tile output handshakes)
// Tile layout: oldest sample in the top DW bits, youngest in [DW-1:0].
module win_tile_builder
  import win_pkg::*;
(
  input logic               clk,
  input logic               rst,
  win_tile_builder_if.slave bus
);

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next, cnt_inc;
  logic [TILE_W-1:0] win, win_shift;
  logic              last_pend, last_pend_next;

  logic              in_ready_c;
  logic              accept;
  logic              slot_free;
  logic              shift_en;
  logic [DW-1:0]     shift_val;
  logic              load;
  logic              load_last;
  logic [TILE_W-1:0] load_data;

  assign accept    = bus.in_valid && in_ready_c;
  assign slot_free = !bus.tile_valid || bus.tile_ready;
  assign cnt_inc   = cnt + 1'b1;
  // Window shifts toward the MSBs, so a full window is already in tile order.
  // After a tile completes, the youngest R-1 samples simply stay in place and
  // reach the top again after M more shifts; no explicit copy is needed.
  assign win_shift = {win[TILE_W-DW-1:0], shift_val};

  // State / datapath register
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      cnt            <= '0;
      win            <= '0;
      last_pend      <= 1'b0;
      bus.tile_valid <= 1'b0;
      bus.tile_data  <= '0;
      bus.tile_last  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      last_pend <= last_pend_next;
      if (shift_en) begin
        win <= win_shift;
      end
      if (load) begin
        bus.tile_valid <= 1'b1;
        bus.tile_data  <= load_data;
        bus.tile_last  <= load_last;
      end else if (bus.tile_ready) begin
        bus.tile_valid <= 1'b0;
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    last_pend_next = last_pend;
    shift_en       = 1'b0;
    shift_val      = bus.in_data;
    load           = 1'b0;
    load_last      = 1'b0;
    load_data      = win_shift;

    unique case (state)
      FILL: begin
        if (accept) begin
          shift_en = 1'b1;
          if (cnt_inc == CNT_FULL) begin
            if (slot_free) begin
              load      = 1'b1;
              load_last = bus.in_last;
              cnt_next  = bus.in_last ? '0 : CNT_OVERLAP;
            end else begin
              cnt_next       = CNT_FULL;
              last_pend_next = bus.in_last;
              state_next     = HOLD;
            end
          end else begin
            cnt_next = cnt_inc;
            if (bus.in_last) begin
              state_next = PAD;
            end
          end
        end
      end

      PAD: begin
        shift_en  = 1'b1;
        shift_val = '0;
        if (cnt_inc == CNT_FULL) begin
          if (slot_free) begin
            load       = 1'b1;
            load_last  = 1'b1;
            cnt_next   = '0;
            state_next = FILL;
          end else begin
            // Padded tile waits in the window exactly like a stalled full tile.
            cnt_next       = CNT_FULL;
            last_pend_next = 1'b1;
            state_next     = HOLD;
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      HOLD: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = win;
          load_last  = last_pend;
          cnt_next   = last_pend ? '0 : CNT_OVERLAP;
          state_next = FILL;
        end
      end

      default: begin
        state_next = FILL;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_c = (state == FILL) && (cnt < CNT_FULL);
  end

  assign bus.in_ready = in_ready_c;

endmodule

// File: tb/tb_win_tile_builder.sv
// Directed + randomized bench for win_tile_builder. Expected tiles come from
// a stream-level model: tiles start every M samples, each holds T samples,
// samples past the end of a stream read as zero, and the tile reaching or
// passing the stream end is the last one.
module tb_win_tile_builder;
  import win_pkg::*;

  typedef struct packed {
    logic [TILE_W-1:0] data;
    logic              last;
  } tile_t;

  typedef logic [DW-1:0] sq_t[$];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  win_tile_builder_if bus();

  win_tile_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- monitor (records only) ----------------
  tile_t       obs_q[$];
  int unsigned obs_cyc[$];
  int unsigned acc_cyc[$];
  int unsigned cyc    = 0;
  int unsigned ir_low = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tile_valid && bus.tile_ready) begin
        tile_t t;
        t.data = bus.tile_data;
        t.last = bus.tile_last;
        obs_q.push_back(t);
        obs_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
      if (!bus.in_ready) ir_low++;
    end
    cyc++;
  end

  // ---------------- checking ----------------
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rd    = 0;
  tile_t       exp_q[$];

  task automatic check_t(input string tag, input tile_t obs, input tile_t expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h/%b required %h/%b", tag, obs.data, obs.last,
             expv.data, expv.last);
    end
  endtask

  task automatic check_i(input string tag, input int unsigned obs, input int unsigned expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model(input sq_t s);
    int unsigned L  = s.size();
    int unsigned st = 0;
    bit          done = 1'b0;
    while (!done) begin
      tile_t t;
      t.data = '0;
      for (int unsigned i = 0; i < T; i++) begin
        if (st + i < L) t.data[(T-1-i)*DW +: DW] = s[st+i];
      end
      t.last = (st + T >= L);
      exp_q.push_back(t);
      done = t.last;
      st += M;
    end
  endfunction

  function automatic sq_t ramp(input int unsigned a, input int unsigned b);
    sq_t q;
    for (int unsigned i = a; i <= b; i++) q.push_back(DW'(i));
    return q;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int unsigned g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      g++;
      if (g > 200) break;
    end
    if (g > 200) begin
      n_cmp++;
      n_bad++;
      $error("FAIL send_timeout: observed in_ready=0 for %0d cycles required 1", g);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic send_stream(input sq_t s, input int unsigned gap_pct, input bit with_last);
    for (int unsigned k = 0; k < s.size(); k++) begin
      int unsigned idle = 0;
      while ($urandom_range(99) < gap_pct && idle < 4) begin
        step();
        idle++;
      end
      send(s[k], with_last && (k == s.size() - 1));
    end
  endtask

  task automatic drain(input string tag);
    int unsigned g = 0;
    while (obs_q.size() - rd < exp_q.size() && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    check_i({tag, "_count"}, obs_q.size() - rd, exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && rd + i < obs_q.size(); i++) begin
      check_t($sformatf("%s_tile%0d", tag, i), obs_q[rd+i], exp_q[i]);
    end
    rd = obs_q.size();
    exp_q.delete();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    sq_t         s;
    tile_t       t;
    tile_t       first;
    int unsigned base_ir, base_acc, rd0, g;
    int          v[9] = '{2, -10, 3, 4, -13, -18, -16, -28, -11};
    logic [TILE_W-1:0] lit;
    bit          rnd_done;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.tile_ready = 1'b1;
    rst            = 1'b1;
    step();
    step();

    // reset values
    @(negedge clk);
    check_i("rst_in_ready", 32'(bus.in_ready), 1);
    check_i("rst_tile_valid", 32'(bus.tile_valid), 0);
    t.data = bus.tile_data;
    t.last = bus.tile_last;
    check_t("rst_tile", t, '0);
    step();
    rst = 1'b0;
    step();

    // continuous 1..15
    base_ir  = ir_low;
    base_acc = acc_cyc.size();
    rd0      = rd;
    s = ramp(1, 15);
    model(s);
    send_stream(s, 0, 1'b1);
    drain("s1");
    check_i("s1_in_ready_low", ir_low - base_ir, 0);
    check_i("s1_tile_spacing", obs_cyc[rd0+1] - obs_cyc[rd0], 6);
    check_i("s1_latency", obs_cyc[rd0] - acc_cyc[base_acc+8], 1);

    // signed samples, exact-length stream
    s.delete();
    for (int unsigned i = 0; i < 9; i++) s.push_back(DW'(v[i]));
    rd0 = rd;
    model(s);
    send_stream(s, 30, 1'b1);
    drain("s2");
    lit = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101;
    t.data = lit;
    t.last = 1'b1;
    if (obs_q.size() > rd0) check_t("s2_literal", obs_q[rd0], t);

    // 1..20: one pad cycle
    base_ir = ir_low;
    s = ramp(1, 20);
    model(s);
    send_stream(s, 0, 1'b1);
    drain("s3");
    check_i("s3_pad_cycles", ir_low - base_ir, 1);

    // short stream then clean restart
    base_ir = ir_low;
    s = ramp(1, 5);
    model(s);
    send_stream(s, 0, 1'b1);
    s = ramp(100, 108);
    model(s);
    send_stream(s, 0, 1'b1);
    drain("s4");
    check_i("s4_pad_cycles", ir_low - base_ir, 4);

    // backpressure
    bus.tile_ready = 1'b0;
    base_acc = acc_cyc.size();
    s = ramp(1, 21);
    model(s);
    first = exp_q[0];
    fork
      send_stream(s, 0, 1'b1);
      begin
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!bus.tile_valid && g < 200);
        t.data = bus.tile_data;
        t.last = bus.tile_last;
        check_t("bp_first", t, first);
        for (int unsigned c = 0; c < 12; c++) begin
          @(negedge clk);
          t.data = bus.tile_data;
          t.last = bus.tile_last;
          check_t($sformatf("bp_stable%0d", c), t, first);
        end
        check_i("bp_accepted", acc_cyc.size() - base_acc, 15);
        check_i("bp_hold_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.tile_ready = 1'b1;
      end
    join
    drain("s5");

    // reset mid-stream
    rd0 = obs_q.size();
    s = ramp(1, 5);
    send_stream(s, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_i("s6_in_ready", 32'(bus.in_ready), 1);
    check_i("s6_tile_valid", 32'(bus.tile_valid), 0);
    step();
    check_i("s6_no_tile", obs_q.size() - rd0, 0);
    s.delete();
    for (int unsigned i = 0; i < 9; i++) s.push_back(DW'($urandom));
    model(s);
    send_stream(s, 0, 1'b1);
    drain("s6");

    // randomized streams with random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int unsigned n = 0; n < 12; n++) begin
          sq_t r;
          int unsigned len = $urandom_range(1, 40);
          for (int unsigned i = 0; i < len; i++) r.push_back(DW'($urandom));
          model(r);
          send_stream(r, 25, 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          step();
          if (!rnd_done) bus.tile_ready = ($urandom_range(99) < 60);
        end
        bus.tile_ready = 1'b1;
      end
    join
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/win_tile_builder.md
Name: win_tile_builder

Overview:
- Upstream stage of the 1-D Winograd F(6,4) core `wc`.
- Takes a serial stream of signed 10-bit samples and assembles overlapping 9-sample input tiles: stride 6, overlap 3.
- Presents each tile as one 90-bit word for `wc` input D, with valid/ready handshakes on both sides.
- Zero-pads the final partial tile of each stream and flags it with tile_last.

Parameters:
DW, 10, sample width (two's complement)
M, 6, outputs per tile (tile stride)
R, 4, filter taps (overlap = R-1)
T, M+R-1 = 9, samples per tile

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  sample present
in_ready  out  1  block accepts sample this cycle
in_data  in  DW  signed sample
in_last  in  1  sample is last of stream (qualified by in_valid&&in_ready)
tile_valid  out  1  tile_data holds a tile
tile_ready  in  1  consumer takes tile this cycle
tile_data  out  T*DW  tile; sample 0 (oldest) at bits [T*DW-1 -: DW], sample T-1 at [DW-1:0]
tile_last  out  1  tile is last of stream (contains padding if partial)

Behaviour:
- Reset values: state FILL, fill count cnt=0, window cleared, tile_valid=0, tile_data=0, tile_last=0, in_ready=1.
- Reset applies at any time and discards any partial window and any pending tile.
- Storage: window shift register of T samples, fill count cnt (0..T), and one output register (tile_data/tile_last/tile_valid).
- Slot free = !tile_valid || tile_ready.
- Accept = in_valid && in_ready.
- Each accept shifts in_data into the youngest position and increments cnt.

State machine:
- FILL:
  - in_ready = (cnt<T).
  - On accept with next cnt==T:
    - If slot free: load output register with the full window on that edge; tile_last=in_last.
    - If in_last: cnt←0 (next stream starts clean, no overlap). Otherwise: window keeps its youngest R-1 samples and cnt←R-1.
    - If slot not free: cnt←T, go to HOLD.
  - On accept with in_last and next cnt<T: go to PAD.
- HOLD:
  - in_ready=0; a pending in_last is remembered.
  - When the slot becomes free: transfer the tile as in FILL, then go to FILL.
- PAD:
  - in_ready=0; shift in one zero per cycle until cnt==T.
  - Then transfer the tile with tile_last=1 (waiting like HOLD if the slot is busy), cnt←0, go to FILL.
  - A stream of 5 samples needs 4 pad cycles; a stream of 3+k new samples needs 6-k pad cycles.

Output register:
- tile_valid clears on tile_ready unless reloaded the same edge.
- Load and consume on the same edge is allowed: full throughput with no bubble.
- tile_data and tile_last stay stable while tile_valid && !tile_ready.

Timing and data handling:
- Latency: tile_valid rises the cycle after the sample completing the tile is accepted.
- Steady state: one tile per 6 accepted samples, in_ready held high.
- No arithmetic on samples: data is moved bit-exact, with no sign extension or saturation.
- Handshake: in_data/in_last are ignored when !in_valid; in_valid with in_ready=0 leaves the window unchanged.

Decomposition:
- Shared package win_pkg holds:
  - Constants DW, M, R, T.
  - State encoding enum {FILL, HOLD, PAD}.
  - Tile-width constant T*DW.
  These constants are also used by `wc` and the downstream stage.
- Single module, no sub-module; window and output register are small enough to stay inline.

Test Plan:
- Continuous samples 1..15, in_last on 15, tile_ready=1 -> two tiles: [1..9] with last=0, then [7..15] with last=1. in_ready never drops. Second tile_valid occurs 6 cycles after the first.
- Samples 2,-10,3,4,-13,-18,-16,-28,-11 with last -> tile_data = 90'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100_1111110101, tile_last=1, no padding.
- Samples 1..20, last on 20 -> tiles [1..9], [7..15], [13..20,0] (one zero pad, last=1); in_ready=0 for exactly 1 pad cycle.
- Short stream 1..5 with last -> single tile [1,2,3,4,5,0,0,0,0] with last=1. The next stream 100..108 yields [100..108] with no carried overlap.
- Backpressure:
  - Stimulus: samples 1..21 back-to-back; tile_ready=0 for 12 cycles after the first tile_valid.
  - Expected while stalled: tile [1..9] stays stable; samples 10..15 are accepted, then in_ready=0 (HOLD).
  - Expected after release: tiles [7..15], [13..21] arrive in order with nothing lost or duplicated.
- Assert rst for 1 cycle after 5 of 9 samples -> no tile emitted. in_ready=1 the next cycle; a subsequent 9-sample stream produces exactly that tile.
